// File: rtl/commit_rob_if.sv
// rtl/commit_rob_if.sv - commit and squash notification interfaces for commit_rob
interface CommitNotif #(parameter int p_seq_num_bits = 5);
  logic                      val;
  logic [p_seq_num_bits-1:0] seq_num;
  logic [31:0]               pc;
  logic [4:0]                waddr;
  logic [31:0]               wdata;
  logic                      wen;

  modport pub (output val, seq_num, pc, waddr, wdata, wen);
  modport sub (input  val, seq_num, pc, waddr, wdata, wen);
endinterface

interface SquashNotif #(parameter int p_seq_num_bits = 5);
  logic                      val;
  logic [p_seq_num_bits-1:0] seq_num;
  logic [31:0]               target;

  modport pub (output val, seq_num, target);
  modport sub (input  val, seq_num, target);
endinterface

// File: rtl/commit_rob.sv
// rtl/commit_rob.sv - in-order commit reorder buffer indexed by sequence number
// Optional same-cycle completion-to-commit bypass is enabled by defining ROB_BYPASS_EN.
module commit_rob #(
  parameter int p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      complete_val,
  output logic                      complete_rdy,
  input  logic [p_seq_num_bits-1:0] complete_seq_num,
  input  logic [31:0]               complete_pc,
  input  logic [4:0]                complete_waddr,
  input  logic [31:0]               complete_wdata,
  input  logic                      complete_wen,
  CommitNotif.pub                   commit,
  SquashNotif.sub                   squash
);

  localparam int c_depth = 2 ** p_seq_num_bits;

  typedef struct packed {
    logic [p_seq_num_bits-1:0] seq_num;
    logic [31:0]               pc;
    logic [4:0]                waddr;
    logic [31:0]               wdata;
    logic                      wen;
  } entry_t;

  logic [c_depth-1:0]        r_valid;
  entry_t                    r_entry [c_depth];
  logic [p_seq_num_bits-1:0] r_head;

  entry_t                    w_cmp_entry;
  entry_t                    w_head_entry;
  entry_t                    w_out;
  logic                      w_head_valid;
  logic [p_seq_num_bits-1:0] w_sq_age;
  logic                      w_cmp_young;
  logic                      w_bypass;
  logic                      w_commit_val;
  logic                      w_wr_en;
  logic [c_depth-1:0]        w_valid_next;

  // Distance from head, wrapping; larger means younger.
  function automatic logic [p_seq_num_bits-1:0] f_age(
    input logic [p_seq_num_bits-1:0] x,
    input logic [p_seq_num_bits-1:0] h
  );
    return x - h;
  endfunction

  assign complete_rdy = 1'b1;

  assign w_cmp_entry = '{seq_num: complete_seq_num, pc: complete_pc, waddr: complete_waddr,
                         wdata: complete_wdata, wen: complete_wen};
  assign w_head_entry = r_entry[r_head];
  assign w_head_valid = r_valid[r_head];
  assign w_sq_age     = f_age(squash.seq_num, r_head);
  assign w_cmp_young  = squash.val && (f_age(complete_seq_num, r_head) > w_sq_age);

`ifdef ROB_BYPASS_EN
  // The head always has age 0, so a squash can never make a bypassed completion younger.
  assign w_bypass = !rst && complete_val && (complete_seq_num == r_head) && !w_head_valid;
  assign w_out    = w_bypass ? w_cmp_entry : w_head_entry;
`else
  assign w_bypass = 1'b0;
  assign w_out    = w_head_entry;
`endif

  assign w_commit_val = !rst && (w_head_valid || w_bypass);
  assign w_wr_en      = complete_val && !w_cmp_young && !w_bypass;

  // Commit clear, then squash clear, then completion set, so a same-index completion wins.
  always_comb begin
    w_valid_next = r_valid;
    if (w_head_valid) w_valid_next[r_head] = 1'b0;
    for (int i = 0; i < c_depth; i++) begin
      if (squash.val && (f_age(p_seq_num_bits'(i), r_head) > w_sq_age)) begin
        w_valid_next[i] = 1'b0;
      end
    end
    if (w_wr_en) w_valid_next[complete_seq_num] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_head  <= '0;
    end else begin
      r_valid <= w_valid_next;
      if (w_commit_val) r_head <= r_head + p_seq_num_bits'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) r_entry[complete_seq_num] <= w_cmp_entry;
  end

  always_comb begin
    commit.val     = w_commit_val;
    commit.seq_num = r_head;
    commit.pc      = w_out.pc;
    commit.waddr   = w_out.waddr;
    commit.wdata   = w_out.wdata;
    commit.wen     = w_out.wen;
  end

`ifndef SYNTHESIS
  function automatic string trace(input int trace_level);
    string s;
    s = $sformatf("%0d|%s|%s", r_head,
                  complete_val ? $sformatf("%0d", complete_seq_num) : " ",
                  w_commit_val ? $sformatf("%0d", w_out.seq_num) : " ");
    if (trace_level > 1) s = {s, $sformatf(" pc=%h tgt=%h", w_out.pc, squash.target)};
    return s;
  endfunction

  // Completing an entry that is still valid (and not leaving this cycle) is an upstream error.
  assert property (@(posedge clk) disable iff (rst)
    !(w_wr_en && r_valid[complete_seq_num] && !(w_head_valid && complete_seq_num == r_head)));
`endif

endmodule

// File: tb/tb_commit_rob.sv
// tb/tb_commit_rob.sv - randomized and directed self-checking bench for commit_rob
module tb_commit_rob;
  localparam int P = 3;
  localparam int N = 2 ** P;
`ifdef ROB_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         cval;
  logic         complete_rdy;
  logic [P-1:0] cseq;
  logic [31:0]  cpc;
  logic [4:0]   cwaddr;
  logic [31:0]  cwdata;
  logic         cwen;

  CommitNotif #(.p_seq_num_bits(P)) commit_if ();
  SquashNotif #(.p_seq_num_bits(P)) squash_if ();

  commit_rob #(.p_seq_num_bits(P)) dut (
    .clk              (clk),
    .rst              (rst),
    .complete_val     (cval),
    .complete_rdy     (complete_rdy),
    .complete_seq_num (cseq),
    .complete_pc      (cpc),
    .complete_waddr   (cwaddr),
    .complete_wdata   (cwdata),
    .complete_wen     (cwen),
    .commit           (commit_if),
    .squash           (squash_if)
  );

  always #5 clk = ~clk;

  bit          m_valid [N];
  logic [31:0] m_pc    [N];
  logic [4:0]  m_waddr [N];
  logic [31:0] m_wdata [N];
  logic        m_wen   [N];
  int          m_head;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int log_seq[$];
  int log_cyc[$];
  int log_pc[$];
  int log_waddr[$];
  int log_wdata[$];

  function automatic int age(input int x, input int h);
    return (x - h) & (N - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  // One cycle: compare DUT against the model, then advance the model across the edge.
  task automatic tick();
    bit          e_val;
    bit          byp;
    logic [31:0] e_pc, e_wdata;
    logic [4:0]  e_waddr;
    logic        e_wen;
    int          oh;
    #1;
    e_val = 0; byp = 0; e_pc = 0; e_wdata = 0; e_waddr = 0; e_wen = 0;
    if (rst) begin
      e_val = 0;
    end else if (m_valid[m_head]) begin
      e_val = 1; e_pc = m_pc[m_head]; e_waddr = m_waddr[m_head];
      e_wdata = m_wdata[m_head]; e_wen = m_wen[m_head];
    end
`ifdef ROB_BYPASS_EN
    else if (cval && int'(cseq) == m_head) begin
      e_val = 1; byp = 1; e_pc = cpc; e_waddr = cwaddr; e_wdata = cwdata; e_wen = cwen;
    end
`endif
    chk("rdy", complete_rdy, 1);
    chk("val", commit_if.val, e_val);
    chk("seq", commit_if.seq_num, m_head);
    if (e_val) begin
      chk("pc", commit_if.pc, e_pc);
      chk("waddr", commit_if.waddr, e_waddr);
      chk("wdata", commit_if.wdata, e_wdata);
      chk("wen", commit_if.wen, e_wen);
    end
    if (commit_if.val === 1'b1) begin
      log_seq.push_back(int'(commit_if.seq_num));
      log_cyc.push_back(cycle);
      log_pc.push_back(int'(commit_if.pc));
      log_waddr.push_back(int'(commit_if.waddr));
      log_wdata.push_back(int'(commit_if.wdata));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      m_head = 0;
    end else begin
      oh = m_head;
      if (e_val) begin
        if (!byp) m_valid[oh] = 0;
        m_head = (oh + 1) % N;
      end
      if (squash_if.val) begin
        for (int i = 0; i < N; i++)
          if (age(i, oh) > age(int'(squash_if.seq_num), oh)) m_valid[i] = 0;
      end
      if (cval && !byp && !(squash_if.val && age(int'(cseq), oh) > age(int'(squash_if.seq_num), oh))) begin
        m_valid[cseq] = 1; m_pc[cseq] = cpc; m_waddr[cseq] = cwaddr;
        m_wdata[cseq] = cwdata; m_wen[cseq] = cwen;
      end
    end
    cycle++;
    #1;
  endtask

  task automatic idle(input int n);
    cval = 0; squash_if.val = 0; rst = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    log_seq.delete(); log_cyc.delete(); log_pc.delete(); log_waddr.delete(); log_wdata.delete();
  endtask

  task automatic do_reset();
    cval = 0; squash_if.val = 0; rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic comp(input int s, input logic [31:0] pc, input logic [4:0] wa,
                      input logic [31:0] wd, input logic we);
    cval = 1; cseq = P'(s); cpc = pc; cwaddr = wa; cwdata = wd; cwen = we;
    tick();
    cval = 0;
  endtask

  task automatic compd(input int s);
    comp(s, 32'h1000 + 32'(s) * 4, 5'(s + 1), 32'hD000 + 32'(s), 1'b1);
  endtask

  task automatic chk_log(input string name, input int exp[$]);
    chk({name, "_n"}, log_seq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_seq.size(); i++)
      chk({name, "_seq"}, log_seq[i], exp[i]);
  endtask

  initial begin
    int t0;
    int s;
    bit found;
    rst = 1; cval = 0; cseq = 0; cpc = 0; cwaddr = 0; cwdata = 0; cwen = 0;
    squash_if.val = 0; squash_if.seq_num = 0; squash_if.target = 0;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_pc[i] = 0; m_waddr[i] = 0; m_wdata[i] = 0; m_wen[i] = 0;
    end
    m_head = 0;
    @(posedge clk); #1;

    // Single completion after reset
    do_reset();
    chk("rst_head", commit_if.seq_num, 0);
    chk("rst_val", commit_if.val, 0);
    clear_log();
    t0 = cycle;
    comp(0, 32'h200, 5'd3, 32'hAB, 1'b1);
    idle(2);
    chk_log("A", '{0});
    if (log_seq.size() == 1) begin
      chk("A_lat", log_cyc[0] - t0, LAT);
      chk("A_pc", log_pc[0], 32'h200);
      chk("A_waddr", log_waddr[0], 3);
      chk("A_wdata", log_wdata[0], 32'hAB);
    end
    chk("A_head", commit_if.seq_num, 1);

    // Out-of-order completions commit in order
    do_reset(); clear_log();
    compd(2); compd(1);
    t0 = cycle;
    compd(0);
    idle(5);
    chk_log("B", '{0, 1, 2});
    if (log_seq.size() == 3) begin
      chk("B_lat0", log_cyc[0] - t0, LAT);
      chk("B_lat1", log_cyc[1] - t0, LAT + 1);
      chk("B_lat2", log_cyc[2] - t0, LAT + 2);
    end
    chk("B_head", commit_if.seq_num, 3);

    // Squash clears younger entries
    do_reset(); clear_log();
    compd(1); compd(2); compd(3);
    squash_if.val = 1; squash_if.seq_num = 3'd1; tick(); squash_if.val = 0;
    compd(0);
    idle(4);
    chk_log("C", '{0, 1});
    chk("C_head", commit_if.seq_num, 2);

    // Completion racing a squash
    do_reset();
    compd(0); compd(1); compd(2);
    idle(4);
    chk("D_head0", commit_if.seq_num, 3);
    clear_log();
    squash_if.val = 1; squash_if.seq_num = 3'd4;
    cval = 1; cseq = 3'd6; cpc = 32'h66; cwaddr = 5'd6; cwdata = 32'h666; cwen = 1;
    tick();
    cseq = 3'd4; cpc = 32'h44; cwaddr = 5'd4; cwdata = 32'h444;
    tick();
    cval = 0; squash_if.val = 0;
    compd(3); compd(5);
    idle(4);
    chk_log("D", '{3, 4, 5});
    chk("D_head", commit_if.seq_num, 6);
    chk("D_val", commit_if.val, 0);

    // Head wraps
    do_reset();
    for (int i = 0; i < 6; i++) compd(i);
    idle(4);
    chk("E_head0", commit_if.seq_num, 6);
    clear_log();
    compd(6); compd(7); compd(0); compd(1);
    idle(4);
    chk_log("E", '{6, 7, 0, 1});
    chk("E_head", commit_if.seq_num, 2);

    // Mid-operation reset discards pending entries
    do_reset();
    compd(3); compd(2); compd(1);
`ifndef ROB_BYPASS_EN
    compd(0);
`endif
    clear_log();
    rst = 1; tick(); rst = 0;
    idle(3);
    chk("F_none", log_seq.size(), 0);
    chk("F_head", commit_if.seq_num, 0);
    compd(0);
    idle(2);
    chk_log("F", '{0});

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(199) == 0);
      cval = 0;
      if ($urandom_range(9) < 6) begin
        s = $urandom_range(N - 1);
        found = 0;
        for (int k = 0; k < N && !found; k++) begin
          if (!m_valid[(s + k) % N]) begin
            found = 1; s = (s + k) % N;
          end
        end
        if (found) begin
          cval = 1; cseq = P'(s); cpc = $urandom; cwaddr = 5'($urandom);
          cwdata = $urandom; cwen = 1'($urandom);
        end
      end
      squash_if.val = ($urandom_range(9) == 0);
      squash_if.seq_num = P'($urandom);
      squash_if.target = $urandom;
      tick();
    end
    idle(N + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
